// File: rtl/ptw_arb_pkg.sv
// ptw_arb_pkg: shared FSM state and owner encodings for the page-table-walk read arbiter.
package ptw_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  typedef enum logic {OWNER_ITLB = 1'b0, OWNER_DTLB = 1'b1} owner_t;
endpackage

// File: rtl/ptw_arb_pick.sv
// ptw_arb_pick: combinational ITLB/DTLB winner select.
// PTW_ARB_DTLB_PRIO_EN selects fixed DTLB priority; otherwise round-robin on the last owner.
module ptw_arb_pick
  import ptw_arb_pkg::*;
(
  input  logic   req_itlb_i,
  input  logic   req_dtlb_i,
  input  owner_t last_i,
  output owner_t win_o
);
`ifdef PTW_ARB_DTLB_PRIO_EN
  logic [1:0] unused_in;
  assign unused_in = {req_itlb_i, last_i};
  assign win_o = owner_t'(req_dtlb_i);
`else
  // On contention the requester that did not own the last delivered completion wins.
  assign win_o = owner_t'((req_itlb_i && req_dtlb_i) ? (last_i == OWNER_ITLB) : req_dtlb_i);
`endif
endmodule

// File: rtl/ptw_arbiter.sv
// ptw_arbiter: arbitrates ITLB/DTLB page-table reads onto one memory read port, with satp flush.
// PTW_ARB_DTLB_PRIO_EN: fixed DTLB priority instead of round-robin.
module ptw_arbiter
  import ptw_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_itlb,
  input  logic [ADDR_WIDTH-1:0] addr_itlb,
  output logic                  rvalid_itlb,
  input  logic                  req_dtlb,
  input  logic [ADDR_WIDTH-1:0] addr_dtlb,
  output logic                  rvalid_dtlb,
  output logic [DATA_WIDTH-1:0] rdata_out,
  output logic                  ren_mem,
  output logic [ADDR_WIDTH-1:0] raddr_mem,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  input  logic                  rvalid_mem,
  input  logic                  flush,
  output logic                  busy
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  owner_t                owner_q, owner_d, last_q, win;
  logic                  grant, deliver;

  ptw_arb_pick u_pick (
    .req_itlb_i(req_itlb),
    .req_dtlb_i(req_dtlb),
    .last_i    (last_q),
    .win_o     (win)
  );

  assign grant   = (state_q == IDLE) && !flush && (req_itlb || req_dtlb);
  assign deliver = (state_q == BUSY) && rvalid_mem && !flush;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = BUSY;
        owner_d = win;
        addr_d  = (win == OWNER_DTLB) ? addr_dtlb : addr_itlb;
      end
      BUSY:    state_d = rvalid_mem ? IDLE : (flush ? DRAIN : BUSY);
      DRAIN:   state_d = rvalid_mem ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      owner_q <= OWNER_ITLB;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      owner_q <= owner_d;
    end
  end

`ifdef PTW_ARB_DTLB_PRIO_EN
  assign last_q = OWNER_DTLB;
`else
  // Reset to DTLB so the first contested grant goes to ITLB.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) last_q <= OWNER_DTLB;
    else if (deliver) last_q <= owner_q;
  end
`endif

  assign busy        = state_q != IDLE;
  assign ren_mem     = busy;
  assign raddr_mem   = busy ? addr_q : '0;
  assign rvalid_itlb = deliver && (owner_q == OWNER_ITLB);
  assign rvalid_dtlb = deliver && (owner_q == OWNER_DTLB);
  assign rdata_out   = deliver ? rdata_mem : '0;
endmodule
